// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   hazard_state_e : data-memory access sequencer states (RUN, WAIT, ERROR)
//   stage_ctrl_t   : per-pipeline-register control pair {enable, flush}
//   REG_X0         : hard-wired zero register address
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun,
    StWait,
    StError
  } hazard_state_e;

  typedef struct packed {
    logic enable;
    logic flush;
  } stage_ctrl_t;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of hazard inputs, data-memory handshake and per-stage controls.
//   master : pipeline side; drives hazard sources and dmem_ready, observes controls
//   slave  : hazard controller; consumes hazard sources, drives all controls
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned CNT_WIDTH = 32
);
  logic [4:0]           id_rs1_addr;
  logic [4:0]           id_rs2_addr;
  logic                 ex_MemRead;
  logic [4:0]           ex_rd_addr;
  logic                 ex_branch_taken;
  logic                 mem_MemRead;
  logic                 mem_MemWrite;
  logic                 dmem_ready;
  logic                 dmem_req;
  logic                 pc_enable;
  logic                 if_id_enable;
  logic                 id_ex_enable;
  logic                 ex_mem_enable;
  logic                 mem_wb_enable;
  logic                 if_id_flush;
  logic                 id_ex_flush;
  logic                 ex_mem_flush;
  logic                 mem_wb_flush;
  logic                 mem_timeout_err;
  logic [CNT_WIDTH-1:0] stall_cycles;

  modport master (
    output id_rs1_addr, id_rs2_addr, ex_MemRead, ex_rd_addr, ex_branch_taken,
           mem_MemRead, mem_MemWrite, dmem_ready,
    input  dmem_req, pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, mem_timeout_err,
           stall_cycles
  );

  modport slave (
    input  id_rs1_addr, id_rs2_addr, ex_MemRead, ex_rd_addr, ex_branch_taken,
           mem_MemRead, mem_MemWrite, dmem_ready,
    output dmem_req, pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, mem_timeout_err,
           stall_cycles
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_stall_counter.sv
// Saturating performance counter.
//   clk   : clock
//   rst   : asynchronous active-high reset, clears count
//   inc   : add one on this clock edge
//   count : current value; holds at all-ones instead of wrapping
module hazard_stall_counter #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_WIDTH{1'b1}})) begin
      count_d = count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard sequencer: derives PC and IF/ID, ID/EX, EX/MEM, MEM/WB enables/flushes
// from EX-stage redirects, load-use dependencies and a multi-cycle data-memory handshake.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of pipeline_hazard_ctrl_if (hazard inputs, dmem handshake,
//              stage controls, sticky timeout error, stall-cycle counter)
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam int unsigned TmoWidth = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoWidth-1:0] TmoLast = TmoWidth'(TIMEOUT_CYCLES - 1);

  hazard_state_e       state_q, state_d;
  logic [TmoWidth-1:0] tmo_q, tmo_d;
  logic                err_q;

  logic        mem_access;
  logic        load_use;
  logic        mem_stall;
  logic        pc_en;
  stage_ctrl_t if_id_c, id_ex_c, ex_mem_c, mem_wb_c;

  assign mem_access = bus.mem_MemRead | bus.mem_MemWrite;
  assign load_use   = bus.ex_MemRead && (bus.ex_rd_addr != REG_X0) &&
                      ((bus.ex_rd_addr == bus.id_rs1_addr) ||
                       (bus.ex_rd_addr == bus.id_rs2_addr));
  assign mem_stall  = mem_access && !bus.dmem_ready && (state_q != StError);

  // Access sequencer and watchdog
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      StRun: begin
        tmo_d = '0;
        if (mem_stall) state_d = StWait;
      end
      StWait: begin
        if (bus.dmem_ready) begin
          state_d = StRun;
          tmo_d   = '0;
        end else if (tmo_q == TmoLast) begin
          state_d = StError;
        end else begin
          tmo_d = tmo_q + TmoWidth'(1);
        end
      end
      StError: ;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      if (state_d == StError) err_q <= 1'b1;
    end
  end

  // Stage controls, highest-priority hazard first. Reset and ERROR both freeze everything.
  always_comb begin
    pc_en    = 1'b0;
    if_id_c  = '0;
    id_ex_c  = '0;
    ex_mem_c = '0;
    mem_wb_c = '0;
    if (rst || (state_q == StError)) begin
      pc_en = 1'b0;
    end else if (mem_stall) begin
      // Upstream holds; a bubble goes into WB so the MEM instruction is not written twice
      mem_wb_c = '{enable: 1'b1, flush: 1'b1};
    end else if (bus.ex_branch_taken) begin
      pc_en           = 1'b1;
      if_id_c         = '{enable: 1'b1, flush: 1'b1};
      id_ex_c         = '{enable: 1'b1, flush: 1'b1};
      ex_mem_c.enable = 1'b1;
      mem_wb_c.enable = 1'b1;
    end else if (load_use) begin
      id_ex_c         = '{enable: 1'b1, flush: 1'b1};
      ex_mem_c.enable = 1'b1;
      mem_wb_c.enable = 1'b1;
    end else begin
      pc_en           = 1'b1;
      if_id_c.enable  = 1'b1;
      id_ex_c.enable  = 1'b1;
      ex_mem_c.enable = 1'b1;
      mem_wb_c.enable = 1'b1;
    end
  end

  assign bus.dmem_req        = mem_access && !rst && (state_q != StError);
  assign bus.pc_enable       = pc_en;
  assign bus.if_id_enable    = if_id_c.enable;
  assign bus.id_ex_enable    = id_ex_c.enable;
  assign bus.ex_mem_enable   = ex_mem_c.enable;
  assign bus.mem_wb_enable   = mem_wb_c.enable;
  assign bus.if_id_flush     = if_id_c.flush;
  assign bus.id_ex_flush     = id_ex_c.flush;
  assign bus.ex_mem_flush    = ex_mem_c.flush;
  assign bus.mem_wb_flush    = mem_wb_c.flush;
  assign bus.mem_timeout_err = err_q;

  hazard_stall_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_stall_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (!pc_en),
    .count (bus.stall_cycles)
  );

endmodule
